cam_capture_ctrl: RTL and testbench
===================================

# cam_capture_ctrl

Frame capture controller that sits behind the camera input stage and sequences writes of stereo pixel data into a double-buffered frame store. It arms on a host command and starts only on a clean frame boundary, never on a partial frame. It generates write strobes and addresses, measures frame geometry, checks it against expected values, and runs single-shot or continuous capture with a graceful stop.

## Interface
Parameters:
- PIXEL_WIDTH, 8, bits per pixel per channel (L and R)
- H_BITS, 11, width of pixel-per-line counters
- V_BITS, 10, width of line-per-frame counters
- ADDR_WIDTH, 21, frame-store word address width; must be ≥ H_BITS+V_BITS

Ports:
- CLK  in  1  pixel clock; the only clock
- RST_N  in  1  asynchronous, active-low reset
- iVSYNC  in  1  frame valid, active-high level, already polarity-corrected
- iDE  in  1  pixel valid, active-high, already polarity-corrected
- iDATA_L  in  PIXEL_WIDTH  left pixel
- iDATA_R  in  PIXEL_WIDTH  right pixel
- iSTART  in  1  one-cycle command pulse: arm capture
- iSTOP  in  1  one-cycle command pulse: stop capture
- iCONT  in  1  1 = continuous capture, 0 = single frame; sampled on accepted iSTART
- iEXP_W  in  H_BITS  expected pixels per line; sampled on accepted iSTART
- iEXP_H  in  V_BITS  expected lines per frame; sampled on accepted iSTART
- oWE  out  1  frame-store write strobe
- oWADDR  out  ADDR_WIDTH  write address, pixel index within the frame
- oWDATA  out  2*PIXEL_WIDTH  {L,R} packed, L in the MSBs
- oBANK  out  1  buffer bank currently being written
- oBUSY  out  1  state is not IDLE
- oFRAME_DONE  out  1  one-cycle pulse at the end of each captured frame
- oERR_SIZE  out  1  sticky flag: geometry mismatch; cleared on accepted iSTART
- oMEAS_W  out  H_BITS  pixel count of the last line of the last captured frame
- oMEAS_H  out  V_BITS  line count of the last captured frame
- oFRAME_CNT  out  16  frames completed since the accepted iSTART; wraps

## Operation
- iVSYNC and iDE are registered internally once, together with the data, and edges are detected on the registered copies. SOF is the rise of registered iVSYNC. EOF is its fall. End of line is the fall of registered iDE.
- States:
  - IDLE: iSTART is accepted here only. iSTART loads the config, clears oERR_SIZE and oFRAME_CNT, then goes to WAIT_GAP.
  - WAIT_GAP: waits for registered iVSYNC = 0, then goes to WAIT_SOF. If iVSYNC is already 0, this takes one cycle.
  - WAIT_SOF: on SOF, clears the pixel, line and address counters and goes to CAPTURE.
  - CAPTURE: each registered iDE = 1 cycle produces oWE = 1 and data, and the address increments afterward.
    - At end of line, the line count increments and the pixel count is compared with EXP_W. On mismatch, oERR_SIZE is set. The pixel count is copied to oMEAS_W and then cleared.
    - At EOF, the line count is compared with EXP_H. The controller updates oMEAS_H, pulses oFRAME_DONE, increments oFRAME_CNT and toggles oBANK.
    - After EOF it goes to WAIT_SOF if CONT = 1 and no stop is pending; otherwise it goes to IDLE.
- Address limit: writes are suppressed when oWADDR ≥ EXP_W*EXP_H (a product registered at iSTART). oERR_SIZE is set instead, and the address stops incrementing.
- Width rules:
  - Pixel and line counters saturate at all-ones.
  - A line longer than 2^H_BITS-1 counts as a mismatch.
- iSTOP behaviour:
  - In WAIT_GAP or WAIT_SOF: return to IDLE on the next cycle, with no FRAME_DONE.
  - In CAPTURE: set stop-pending. The current frame finishes normally, then the controller goes to IDLE.
- iSTART and iSTOP in the same cycle in IDLE: iSTOP wins and the state stays IDLE. iSTART in any other state is ignored.
- EOF in the same cycle as an end of line: the line is counted before the height compare.

## Timing
- Reset values: all outputs are 0, the state is IDLE, bank is 0 and stop-pending is clear.
- Write latency: oWE, oWADDR and oWDATA are registered and appear 2 cycles after the corresponding iDE/iDATA sample at the port.
  - Cycle N+1: input register.
  - Cycle N+2: output register.
- oWADDR for the first pixel of a frame is 0.
- oFRAME_DONE is asserted 2 cycles after iVSYNC falls at the port. oMEAS_H, oFRAME_CNT, oBANK and oERR_SIZE update in the same cycle as oFRAME_DONE.
- oBUSY follows the state register: it is 1 in the cycle after iSTART is accepted, and 0 in the cycle after the last state exit to IDLE.
- Reset mid-frame: the block immediately returns to reset values and does not resume until a new iSTART.

## Test plan
- Single frame: iSTART with CONT = 0, W = 4, H = 3; drive a 4×3 frame. Required response:
  - 12 writes at addresses 0–11 with correct {L,R} data.
  - One oFRAME_DONE pulse, oMEAS_W = 4, oMEAS_H = 3, oFRAME_CNT = 1, oBANK = 1, oERR_SIZE = 0.
  - oBUSY = 0 afterward.
- Partial-frame rejection: iSTART while iVSYNC is high, mid-frame. Required response: no writes until iVSYNC falls and the next SOF; the first write of that frame is at address 0.
- Continuous with graceful stop: CONT = 1, with three 4×3 frames. Required response:
  - oBANK toggles 0→1→0→1 and oFRAME_CNT goes 1, 2, 3.
  - iSTOP pulsed during frame 3 still completes frame 3 (12 writes, FRAME_DONE), then the state is IDLE and frame 4 produces no writes.
- Size error: W = 4, H = 3; drive one 5-pixel line and 4 lines in total. Required response:
  - oERR_SIZE = 1 and stays sticky.
  - Writes stop at address 11, oMEAS_H = 4.
  - The next iSTART clears the flag.
- Command corners:
  - iSTART and iSTOP in the same cycle in IDLE: oBUSY stays 0.
  - iSTOP in WAIT_SOF: return to IDLE with no FRAME_DONE.
  - RST_N low mid-capture: all outputs go to 0 immediately.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
// Stereo frame capture controller: arms on a host command, starts on a clean SOF,
// writes {L,R} pixels into a double-buffered frame store and checks frame geometry.
module cam_capture_ctrl #(
    parameter int PIXEL_WIDTH = 8,
    parameter int H_BITS      = 11,
    parameter int V_BITS      = 10,
    parameter int ADDR_WIDTH  = 21
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     iVSYNC,
    input  logic                     iDE,
    input  logic [PIXEL_WIDTH-1:0]   iDATA_L,
    input  logic [PIXEL_WIDTH-1:0]   iDATA_R,
    input  logic                     iSTART,
    input  logic                     iSTOP,
    input  logic                     iCONT,
    input  logic [H_BITS-1:0]        iEXP_W,
    input  logic [V_BITS-1:0]        iEXP_H,
    output logic                     oWE,
    output logic [ADDR_WIDTH-1:0]    oWADDR,
    output logic [2*PIXEL_WIDTH-1:0] oWDATA,
    output logic                     oBANK,
    output logic                     oBUSY,
    output logic                     oFRAME_DONE,
    output logic                     oERR_SIZE,
    output logic [H_BITS-1:0]        oMEAS_W,
    output logic [V_BITS-1:0]        oMEAS_H,
    output logic [15:0]              oFRAME_CNT
);

    localparam int PROD_W = H_BITS + V_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_GAP,
        S_WAIT_SOF,
        S_CAPTURE
    } state_t;

    state_t state, state_n;

    logic                   vs_r, vs_d, de_r, de_d;
    logic [PIXEL_WIDTH-1:0] dl_r, dr_r;
    logic                   sof, eof, eol;

    logic                   cont_q, stop_pend;
    logic [H_BITS-1:0]      exp_w_q;
    logic [V_BITS-1:0]      exp_h_q;
    logic [ADDR_WIDTH-1:0]  limit_q;
    logic [PROD_W-1:0]      prod;

    logic [H_BITS-1:0]      pix_cnt;
    logic                   pix_ovf;
    logic [V_BITS-1:0]      line_cnt, line_eff;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   wr_ok;

    logic                   start_acc, cap_clear, stop_set;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vs_r <= 1'b0;
            vs_d <= 1'b0;
            de_r <= 1'b0;
            de_d <= 1'b0;
            dl_r <= '0;
            dr_r <= '0;
        end else begin
            vs_r <= iVSYNC;
            vs_d <= vs_r;
            de_r <= iDE;
            de_d <= de_r;
            dl_r <= iDATA_L;
            dr_r <= iDATA_R;
        end
    end

    assign sof   = vs_r & ~vs_d;
    assign eof   = ~vs_r & vs_d;
    assign eol   = ~de_r & de_d;
    assign prod  = PROD_W'(iEXP_W) * PROD_W'(iEXP_H);
    assign wr_ok = (addr < limit_q);
    assign oBUSY = (state != S_IDLE);

    // A line ending in the EOF cycle is counted before the height compare.
    assign line_eff = (eol && (line_cnt != '1)) ? line_cnt + V_BITS'(1) : line_cnt;

    always_comb begin
        state_n   = state;
        start_acc = 1'b0;
        cap_clear = 1'b0;
        stop_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (iSTART && !iSTOP) begin
                    start_acc = 1'b1;
                    state_n   = S_WAIT_GAP;
                end
            end
            S_WAIT_GAP: begin
                if (iSTOP)      state_n = S_IDLE;
                else if (!vs_r) state_n = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                if (iSTOP) begin
                    state_n = S_IDLE;
                end else if (sof) begin
                    cap_clear = 1'b1;
                    state_n   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                stop_set = iSTOP;
                if (eof) begin
                    if (cont_q && !stop_pend && !iSTOP) state_n = S_WAIT_SOF;
                    else                                state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_n;
            stop_pend <= (state_n == S_IDLE) ? 1'b0 : (stop_pend | stop_set);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cont_q      <= 1'b0;
            exp_w_q     <= '0;
            exp_h_q     <= '0;
            limit_q     <= '0;
            pix_cnt     <= '0;
            pix_ovf     <= 1'b0;
            line_cnt    <= '0;
            addr        <= '0;
            oWE         <= 1'b0;
            oWADDR      <= '0;
            oWDATA      <= '0;
            oBANK       <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oERR_SIZE   <= 1'b0;
            oMEAS_W     <= '0;
            oMEAS_H     <= '0;
            oFRAME_CNT  <= '0;
        end else begin
            oWE         <= 1'b0;
            oFRAME_DONE <= 1'b0;

            if (start_acc) begin
                cont_q     <= iCONT;
                exp_w_q    <= iEXP_W;
                exp_h_q    <= iEXP_H;
                limit_q    <= ADDR_WIDTH'(prod);
                oERR_SIZE  <= 1'b0;
                oFRAME_CNT <= '0;
            end

            if (cap_clear) begin
                pix_cnt  <= '0;
                pix_ovf  <= 1'b0;
                line_cnt <= '0;
                addr     <= '0;
            end

            if (state == S_CAPTURE) begin
                if (de_r) begin
                    // Saturated counter plus an overflow flag flags over-long lines.
                    if (pix_cnt == '1) pix_ovf <= 1'b1;
                    else               pix_cnt <= pix_cnt + H_BITS'(1);
                    if (wr_ok) begin
                        oWE    <= 1'b1;
                        oWADDR <= addr;
                        oWDATA <= {dl_r, dr_r};
                        addr   <= addr + ADDR_WIDTH'(1);
                    end else begin
                        oERR_SIZE <= 1'b1;
                    end
                end
                if (eol) begin
                    line_cnt <= line_eff;
                    oMEAS_W  <= pix_cnt;
                    if (pix_ovf || (pix_cnt != exp_w_q)) oERR_SIZE <= 1'b1;
                    pix_cnt  <= '0;
                    pix_ovf  <= 1'b0;
                end
                if (eof) begin
                    if (line_eff != exp_h_q) oERR_SIZE <= 1'b1;
                    oMEAS_H     <= line_eff;
                    oFRAME_DONE <= 1'b1;
                    oFRAME_CNT  <= oFRAME_CNT + 16'd1;
                    oBANK       <= ~oBANK;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard testbench for cam_capture_ctrl: expected writes and frame-done records
// are queued while stimulus is driven and compared against what the DUT emits.
module tb_cam_capture_ctrl;

    localparam int PW = 8;
    localparam int HB = 11;
    localparam int VB = 10;
    localparam int AW = 21;

    typedef struct packed {
        logic [31:0]     cyc;
        logic [AW-1:0]   addr;
        logic [2*PW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [HB-1:0] mw;
        logic [VB-1:0] mh;
        logic [15:0]   cnt;
        logic          bank;
        logic          err;
    } done_t;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            iVSYNC = 1'b0, iDE = 1'b0, iSTART = 1'b0, iSTOP = 1'b0, iCONT = 1'b0;
    logic [PW-1:0]   iDATA_L = '0, iDATA_R = '0;
    logic [HB-1:0]   iEXP_W = '0;
    logic [VB-1:0]   iEXP_H = '0;
    logic            oWE, oBANK, oBUSY, oFRAME_DONE, oERR_SIZE;
    logic [AW-1:0]   oWADDR;
    logic [2*PW-1:0] oWDATA;
    logic [HB-1:0]   oMEAS_W;
    logic [VB-1:0]   oMEAS_H;
    logic [15:0]     oFRAME_CNT;

    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;
    int cur_w = 0;
    int cur_h = 0;

    wr_t   exp_wr[$], obs_wr[$];
    done_t exp_done[$], obs_done[$];

    cam_capture_ctrl #(.PIXEL_WIDTH(PW), .H_BITS(HB), .V_BITS(VB), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .iVSYNC(iVSYNC), .iDE(iDE),
        .iDATA_L(iDATA_L), .iDATA_R(iDATA_R), .iSTART(iSTART), .iSTOP(iSTOP),
        .iCONT(iCONT), .iEXP_W(iEXP_W), .iEXP_H(iEXP_H),
        .oWE(oWE), .oWADDR(oWADDR), .oWDATA(oWDATA), .oBANK(oBANK), .oBUSY(oBUSY),
        .oFRAME_DONE(oFRAME_DONE), .oERR_SIZE(oERR_SIZE), .oMEAS_W(oMEAS_W),
        .oMEAS_H(oMEAS_H), .oFRAME_CNT(oFRAME_CNT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (oWE) obs_wr.push_back('{cyc: cyc, addr: oWADDR, data: oWDATA});
        if (oFRAME_DONE)
            obs_done.push_back('{cyc: cyc, mw: oMEAS_W, mh: oMEAS_H, cnt: oFRAME_CNT,
                                 bank: oBANK, err: oERR_SIZE});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        {iVSYNC, iDE, iSTART, iSTOP, iCONT} = '0;
        tick(2);
        RST_N = 1'b1;
        tick(1);
        exp_wr.delete();
        obs_wr.delete();
        exp_done.delete();
        obs_done.delete();
    endtask

    task automatic arm(input logic cont, input int w, input int h);
        iCONT  = cont;
        iEXP_W = HB'(w);
        iEXP_H = VB'(h);
        cur_w  = w;
        cur_h  = h;
        iSTART = 1'b1;
        tick(1);
        iSTART = 1'b0;
    endtask

    // Drives one frame; expected writes/done are queued only when capture is expected.
    task automatic send_frame(input int nlines, input int first_w, input int w, input bit capture,
                              input int start_at, input int stop_at, input int mw, input int mh,
                              input int cnt, input bit bank, input bit err);
        int idx = 0;
        int len;
        wr_t e;
        iVSYNC = 1'b1;
        tick(2);
        for (int l = 0; l < nlines; l++) begin
            len = (l == 0) ? first_w : w;
            for (int p = 0; p < len; p++) begin
                iDE     = 1'b1;
                iDATA_L = PW'($urandom);
                iDATA_R = PW'($urandom);
                iSTART  = (idx == start_at);
                iSTOP   = (idx == stop_at);
                if (capture && idx < cur_w * cur_h) begin
                    e.cyc  = cyc + 2;
                    e.addr = AW'(idx);
                    e.data = {iDATA_L, iDATA_R};
                    exp_wr.push_back(e);
                end
                idx++;
                tick(1);
            end
            iDE    = 1'b0;
            iSTART = 1'b0;
            iSTOP  = 1'b0;
            tick(2);
        end
        iVSYNC = 1'b0;
        if (capture)
            exp_done.push_back('{cyc: cyc + 2, mw: HB'(mw), mh: VB'(mh), cnt: 16'(cnt),
                                 bank: bank, err: err});
        tick(4);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick(1);
        checks++;
        if ({oWE, oWADDR, oWDATA, oBANK, oBUSY, oFRAME_DONE, oERR_SIZE, oMEAS_W, oMEAS_H, oFRAME_CNT} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%h bank=%b busy=%b cnt=%0d, required all 0",
                     oWE, oWADDR, oWDATA, oBANK, oBUSY, oFRAME_CNT);
        end
        do_reset();
        checks++;
        if (oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b required 0", oBUSY);
        end
    endtask

    task automatic test_single_frame();
        wr_t o, e;
        done_t od, ed;
        do_reset();
        arm(1'b0, 4, 3);
        checks++;
        if (oBUSY !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_after_start: got %b required 1", oBUSY);
        end
        tick(2);
        send_frame(3, 4, 4, 1'b1, -1, -1, 4, 3, 1, 1'b1, 1'b0);
        checks++;
        if (obs_wr.size() != exp_wr.size() || obs_done.size() != exp_done.size()) begin
            errors++;
            $display("FAIL single_counts: got writes=%0d done=%0d, required writes=%0d done=%0d",
                     obs_wr.size(), obs_done.size(), exp_wr.size(), exp_done.size());
        end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            o = obs_wr.pop_front();
            e = exp_wr.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single_write: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                         o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
            end
        end
        while (obs_done.size() > 0 && exp_done.size() > 0) begin
            od = obs_done.pop_front();
            ed = exp_done.pop_front();
            checks++;
            if (od !== ed) begin
                errors++;
                $display("FAIL single_done: got %p, required %p", od, ed);
            end
        end
        checks++;
        if (oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_after: got %b required 0", oBUSY);
        end
    endtask

    task automatic test_partial_frame();
        wr_t o, e;
        done_t od, ed;
        do_reset();
        iCONT  = 1'b0;
        iEXP_W = HB'(4);
        iEXP_H = VB'(3);
        cur_w  = 4;
        cur_h  = 3;
        send_frame(3, 4, 4, 1'b0, 5, -1, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (obs_wr.size() != 0 || oBUSY !== 1'b1) begin
            errors++;
            $display("FAIL partial_no_write: got writes=%0d busy=%b, required writes=0 busy=1",
                     obs_wr.size(), oBUSY);
        end
        send_frame(3, 4, 4, 1'b1, -1, -1, 4, 3, 1, 1'b1, 1'b0);
        checks++;
        if (obs_wr.size() != exp_wr.size() || obs_done.size() != exp_done.size()) begin
            errors++;
            $display("FAIL partial_counts: got writes=%0d done=%0d, required writes=%0d done=%0d",
                     obs_wr.size(), obs_done.size(), exp_wr.size(), exp_done.size());
        end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            o = obs_wr.pop_front();
            e = exp_wr.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL partial_write: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                         o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
            end
        end
        while (obs_done.size() > 0 && exp_done.size() > 0) begin
            od = obs_done.pop_front();
            ed = exp_done.pop_front();
            checks++;
            if (od !== ed) begin
                errors++;
                $display("FAIL partial_done: got %p, required %p", od, ed);
            end
        end
    endtask

    task automatic test_continuous_stop();
        wr_t o, e;
        done_t od, ed;
        do_reset();
        arm(1'b1, 4, 3);
        tick(2);
        send_frame(3, 4, 4, 1'b1, -1, -1, 4, 3, 1, 1'b1, 1'b0);
        send_frame(3, 4, 4, 1'b1, -1, -1, 4, 3, 2, 1'b0, 1'b0);
        send_frame(3, 4, 4, 1'b1, -1, 6, 4, 3, 3, 1'b1, 1'b0);
        checks++;
        if (oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL cont_idle_after_stop: got busy=%b required 0", oBUSY);
        end
        send_frame(3, 4, 4, 1'b0, -1, -1, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (obs_wr.size() != exp_wr.size() || obs_done.size() != exp_done.size()) begin
            errors++;
            $display("FAIL cont_counts: got writes=%0d done=%0d, required writes=%0d done=%0d",
                     obs_wr.size(), obs_done.size(), exp_wr.size(), exp_done.size());
        end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            o = obs_wr.pop_front();
            e = exp_wr.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL cont_write: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                         o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
            end
        end
        while (obs_done.size() > 0 && exp_done.size() > 0) begin
            od = obs_done.pop_front();
            ed = exp_done.pop_front();
            checks++;
            if (od !== ed) begin
                errors++;
                $display("FAIL cont_done: got %p, required %p", od, ed);
            end
        end
    endtask

    task automatic test_size_error();
        wr_t o, e;
        done_t od, ed;
        do_reset();
        arm(1'b0, 4, 3);
        tick(2);
        send_frame(4, 5, 4, 1'b1, -1, -1, 4, 4, 1, 1'b1, 1'b1);
        checks++;
        if (obs_wr.size() != exp_wr.size() || obs_done.size() != exp_done.size()) begin
            errors++;
            $display("FAIL size_counts: got writes=%0d done=%0d, required writes=%0d done=%0d",
                     obs_wr.size(), obs_done.size(), exp_wr.size(), exp_done.size());
        end
        while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
            o = obs_wr.pop_front();
            e = exp_wr.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL size_write: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                         o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
            end
        end
        while (obs_done.size() > 0 && exp_done.size() > 0) begin
            od = obs_done.pop_front();
            ed = exp_done.pop_front();
            checks++;
            if (od !== ed) begin
                errors++;
                $display("FAIL size_done: got %p, required %p", od, ed);
            end
        end
        tick(5);
        checks++;
        if (oERR_SIZE !== 1'b1) begin
            errors++;
            $display("FAIL size_err_sticky: got %b required 1", oERR_SIZE);
        end
        arm(1'b0, 4, 3);
        checks++;
        if (oERR_SIZE !== 1'b0 || oFRAME_CNT !== 16'd0) begin
            errors++;
            $display("FAIL size_err_clear: got err=%b cnt=%0d required err=0 cnt=0", oERR_SIZE, oFRAME_CNT);
        end
        iSTOP = 1'b1;
        tick(1);
        iSTOP = 1'b0;
    endtask

    task automatic test_command_corners();
        do_reset();
        iEXP_W = HB'(4);
        iEXP_H = VB'(3);
        iSTART = 1'b1;
        iSTOP  = 1'b1;
        tick(1);
        iSTART = 1'b0;
        iSTOP  = 1'b0;
        checks++;
        if (oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_same_cycle: got busy=%b required 0", oBUSY);
        end
        arm(1'b0, 4, 3);
        tick(2);
        checks++;
        if (oBUSY !== 1'b1) begin
            errors++;
            $display("FAIL wait_sof_busy: got busy=%b required 1", oBUSY);
        end
        iSTOP = 1'b1;
        tick(1);
        iSTOP = 1'b0;
        checks++;
        if (oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL stop_in_wait_sof: got busy=%b required 0", oBUSY);
        end
        send_frame(3, 4, 4, 1'b0, -1, -1, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (obs_wr.size() != 0 || obs_done.size() != 0) begin
            errors++;
            $display("FAIL stop_no_capture: got writes=%0d done=%0d required 0 0", obs_wr.size(), obs_done.size());
        end
        arm(1'b0, 4, 3);
        tick(2);
        iVSYNC = 1'b1;
        tick(2);
        iDE = 1'b1;
        iDATA_L = 8'hA5;
        iDATA_R = 8'h5A;
        tick(2);
        checks++;
        if (oWE !== 1'b1 || oWADDR !== '0 || oWDATA !== 16'hA55A) begin
            errors++;
            $display("FAIL midcap_write: got we=%b addr=%0d data=%h required we=1 addr=0 data=a55a",
                     oWE, oWADDR, oWDATA);
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if ({oWE, oWADDR, oWDATA, oBANK, oBUSY, oFRAME_DONE, oERR_SIZE, oMEAS_W, oMEAS_H, oFRAME_CNT} !== '0) begin
            errors++;
            $display("FAIL midcap_reset: got we=%b addr=%0d busy=%b, required all outputs 0", oWE, oWADDR, oBUSY);
        end
        iDE = 1'b0;
        iVSYNC = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_partial_frame();
        test_continuous_stop();
        test_size_error();
        test_command_corners();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
